// File: rtl/pattern_gen3_pkg.sv
// pattern_gen3 shared types and defaults.
// FSM state encoding and divider width helper.
package pattern_gen_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pg_state_t;

    localparam int PG_WIDTH = 19;
    localparam int PG_DIV   = 4;

    // Counter width for a modulo-div counter, never narrower than 1 bit.
    function automatic int pg_cw(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pattern_gen3_if.sv
// pattern_gen3 control/pattern/serial-output bundle.
// master = stimulus source, slave = the generator.
interface pattern_gen3_if
    import pattern_gen_pkg::*;
#(
    parameter int WIDTH = PG_WIDTH
);
    localparam int IW = $clog2(WIDTH);

    logic             start;
    logic             loop;
    logic [WIDTH-1:0] pat_a;
    logic [WIDTH-1:0] pat_b;
    logic [WIDTH-1:0] pat_c;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic [IW-1:0]    bit_idx;

    modport master (
        output start, loop, pat_a, pat_b, pat_c,
        input  a, b, c, busy, done, bit_idx
    );

    modport slave (
        input  start, loop, pat_a, pat_b, pat_c,
        output a, b, c, busy, done, bit_idx
    );

endinterface

// File: rtl/pattern_gen3_tick_divider.sv
// Modulo-DIV counter with synchronous clear.
// tick is high while the count sits at DIV-1.
module tick_divider
    import pattern_gen_pkg::*;
#(
    parameter int DIV = PG_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = pg_cw(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1 and wrap; clr parks the count at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pattern_gen3.sv
// Three-channel MSB-first serial pattern generator.
// Feeds the A/B/C inputs of nor_gate with skew-free registered bits.
module pattern_gen3
    import pattern_gen_pkg::*;
#(
    parameter int WIDTH = PG_WIDTH,
    parameter int DIV   = PG_DIV
) (
    input  logic          clk,
    input  logic          reset,
    pattern_gen3_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

    pg_state_t        state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_c;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    nxt;
    logic             a_q;
    logic             b_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic             tick;
    logic             clr;

    assign nxt = idx - 1'b1;
    assign clr = (state == IDLE);

    tick_divider #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // Run FSM: capture on start, step one bit per tick, loop or stop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            sh_c   <= '0;
            idx    <= TOP;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            c_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    idx <= TOP;
                    if (bus.start) begin
                        sh_a   <= bus.pat_a;
                        sh_b   <= bus.pat_b;
                        sh_c   <= bus.pat_c;
                        a_q    <= bus.pat_a[WIDTH-1];
                        b_q    <= bus.pat_b[WIDTH-1];
                        c_q    <= bus.pat_c[WIDTH-1];
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        a_q    <= 1'b0;
                        b_q    <= 1'b0;
                        c_q    <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (idx != '0) begin
                            idx <= nxt;
                            a_q <= sh_a[nxt];
                            b_q <= sh_b[nxt];
                            c_q <= sh_c[nxt];
                        end else begin
                            done_q <= 1'b1;
                            idx    <= TOP;
                            if (bus.loop) begin
                                a_q <= sh_a[WIDTH-1];
                                b_q <= sh_b[WIDTH-1];
                                c_q <= sh_c[WIDTH-1];
                            end else begin
                                a_q    <= 1'b0;
                                b_q    <= 1'b0;
                                c_q    <= 1'b0;
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a       = a_q;
    assign bus.b       = b_q;
    assign bus.c       = c_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bit_idx = idx;

endmodule

// File: tb/tb_pattern_gen3.sv
// Self-checking bench for pattern_gen3 at DIV = 1, 4 and 2.
// Per-cycle expectations come from a small model via a queue.
module tb_pattern_gen3;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       c;
        logic       busy;
        logic       done;
        logic [4:0] idx;
    } obs_t;

    typedef struct {
        int          sel;
        logic [18:0] a;
        logic [18:0] b;
        logic [18:0] c;
        int          passes;
        int          nor_steps;
        string       name;
    } vec_t;

    localparam obs_t RST = '{a: 1'b0, b: 1'b0, c: 1'b0,
                             busy: 1'b0, done: 1'b0, idx: 5'd18};

    logic        clk;
    logic        reset;
    logic [2:0]  st;
    logic [2:0]  lp;
    logic [18:0] pa [3];
    logic [18:0] pb [3];
    logic [18:0] pc [3];

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    vec_t tbl[5];

    pattern_gen3_if #(.WIDTH(19)) bus0 ();
    pattern_gen3_if #(.WIDTH(19)) bus1 ();
    pattern_gen3_if #(.WIDTH(19)) bus2 ();

    assign bus0.start = st[0];
    assign bus0.loop  = lp[0];
    assign bus0.pat_a = pa[0];
    assign bus0.pat_b = pb[0];
    assign bus0.pat_c = pc[0];
    assign bus1.start = st[1];
    assign bus1.loop  = lp[1];
    assign bus1.pat_a = pa[1];
    assign bus1.pat_b = pb[1];
    assign bus1.pat_c = pc[1];
    assign bus2.start = st[2];
    assign bus2.loop  = lp[2];
    assign bus2.pat_a = pa[2];
    assign bus2.pat_b = pb[2];
    assign bus2.pat_c = pc[2];

    pattern_gen3 #(.WIDTH(19), .DIV(1)) u_d1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    pattern_gen3 #(.WIDTH(19), .DIV(4)) u_d4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    pattern_gen3 #(.WIDTH(19), .DIV(2)) u_d2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int div_of(input int s);
        case (s)
            0:       return 1;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic obs_t get_obs(input int s);
        obs_t o;
        case (s)
            0: o = {bus0.a, bus0.b, bus0.c, bus0.busy,
                    bus0.done, bus0.bit_idx};
            1: o = {bus1.a, bus1.b, bus1.c, bus1.busy,
                    bus1.done, bus1.bit_idx};
            default: o = {bus2.a, bus2.b, bus2.c, bus2.busy,
                          bus2.done, bus2.bit_idx};
        endcase
        return o;
    endfunction

    task automatic chk(input string nm, input int cyc,
                       input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s cyc %0d: got a%b b%b c%b busy%b done%b idx%0d, want a%b b%b c%b busy%b done%b idx%0d",
                     nm, cyc, g.a, g.b, g.c, g.busy, g.done, g.idx,
                     e.a, e.b, e.c, e.busy, e.done, e.idx);
        end
    endtask

    task automatic chk_int(input string nm, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, g, e);
        end
    endtask

    // Drive one run on DUT s and compare every cycle to the model.
    task automatic run(input int s, input logic [18:0] va,
                       input logic [18:0] vb, input logic [18:0] vc,
                       input int passes, input int repulse,
                       input int chg, input int nor_exp,
                       input string nm);
        int   dv;
        int   n;
        int   cyc;
        int   nors;
        obs_t e;
        obs_t g;
        dv = div_of(s);
        n  = 19 * dv;
        @(posedge clk);
        #1;
        pa[s] = va;
        pb[s] = vb;
        pc[s] = vc;
        lp[s] = (passes > 1);
        st[s] = 1'b1;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < 19; k++) begin
                for (int d = 0; d < dv; d++) begin
                    e.a    = va[18-k];
                    e.b    = vb[18-k];
                    e.c    = vc[18-k];
                    e.busy = 1'b1;
                    e.done = (p > 0 && k == 0 && d == 0);
                    e.idx  = 5'(18 - k);
                    exp_q.push_back(e);
                end
            end
        end
        e = RST;
        e.done = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(RST);
        @(posedge clk);
        #1;
        st[s] = 1'b0;
        cyc  = 0;
        nors = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = get_obs(s);
            chk(nm, cyc, g, e);
            if (g.busy && !(g.a | g.b | g.c)) nors++;
            if (cyc == (passes - 1) * n) lp[s] = 1'b0;
            if (cyc == repulse) st[s] = 1'b1;
            else if (cyc == repulse + 1) st[s] = 1'b0;
            if (cyc == chg) pa[s] = ~pa[s];
            cyc++;
        end
        if (nor_exp >= 0)
            chk_int({nm, "_nor_cycles"}, nors, nor_exp * dv * passes);
    endtask

    initial begin
        st    = '0;
        lp    = '0;
        for (int i = 0; i < 3; i++) begin
            pa[i] = '0;
            pb[i] = '0;
            pc[i] = '0;
        end
        tbl[0] = '{0, 19'b0111111000011110000, 19'b0000111100001111000,
                   19'b0010010001000100010, 1, 5, "plan_d1"};
        tbl[1] = '{1, 19'b1010101010101010101, 19'b0, 19'b0,
                   1, 9, "alt_d4"};
        tbl[2] = '{0, 19'b0111111000011110000, 19'b0000111100001111000,
                   19'b0010010001000100010, 3, 5, "loop3_d1"};
        tbl[3] = '{2, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1, 0, "ones_d2"};
        tbl[4] = '{2, 19'b0, 19'b0, 19'b0, 1, 19, "zeros_d2"};

        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) chk("reset_state", s, get_obs(s), RST);
        #20;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++)
            run(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].passes,
                -10, -10, tbl[i].nor_steps, tbl[i].name);

        run(0, tbl[0].a, tbl[0].b, tbl[0].c, 1, 5, 7, -1, "restart_chg");

        @(posedge clk);
        #1;
        pa[0] = tbl[0].a;
        pb[0] = tbl[0].b;
        pc[0] = tbl[0].c;
        lp[0] = 1'b0;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        for (int i = 0; i <= 10; i++) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 10, get_obs(0), RST);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_idle", i, get_obs(0), RST);
        end

        run(0, tbl[0].a, tbl[0].b, tbl[0].c, 1, -10, -10, 5, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_gen3.md
# pattern_gen3

Three-channel serial stimulus generator that sits directly upstream of `nor_gate`. It captures three WIDTH-bit patterns and drives them MSB-first onto the `nor_gate` inputs A, B and C. Each bit is held for a programmable number of clock cycles. It replaces hand-written `for`-loop stimulus with a synthesizable source, so the same waveform can be driven on hardware.

## Interface
- `WIDTH`, 19: bits per pattern (number of steps), ≥ 2.
- `DIV`, 4: clock cycles each bit is held, ≥ 1.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `start`  in  1: level sampled at the rising edge; begins a run when idle.
- `loop`  in  1: sampled at end of each pass; 1 = repeat the captured patterns.
- `pat_a`  in  WIDTH: pattern for A; bit WIDTH-1 is sent first.
- `pat_b`  in  WIDTH: pattern for B.
- `pat_c`  in  WIDTH: pattern for C.
- `a`, `b`, `c`  out  1 each: serialized bits, registered; connect to `nor_gate` A/B/C.
- `busy`  out  1: high while a run is in progress.
- `done`  out  1: one-cycle pulse at the end of each pass.
- `bit_idx`  out  $clog2(WIDTH): index of the bit currently driven.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - `a`/`b`/`c` = 0, `busy` = 0, `bit_idx` = WIDTH-1.
  - `start` = 1 at an edge: capture `pat_a/b/c` into shadow registers, drive bit WIDTH-1 on that same edge, set `busy` = 1, zero the divider, go to SHIFT.
- SHIFT:
  - Divider counts 0..DIV-1.
  - At DIV-1 with `bit_idx` > 0: decrement `bit_idx`, drive the next lower bit, reset the divider.
- End of pass (divider = DIV-1, `bit_idx` = 0):
  - `done` = 1 on the next cycle (one cycle only).
  - `loop` = 1: reload `bit_idx` = WIDTH-1 from the shadow registers and drive bit WIDTH-1 with no gap; `busy` stays 1.
  - `loop` = 0: outputs go to 0, `busy` = 0, go to IDLE.
- Pattern inputs are ignored after capture; changing them mid-run has no effect.
- `start` while busy is ignored. `start` held high in IDLE after a run begins a new run on the next edge.
- `reset` asserted at any time, including mid-run:
  - immediately forces IDLE, `a`/`b`/`c`/`busy`/`done` = 0, `bit_idx` = WIDTH-1, shadow registers = 0.
  - After deassertion the block waits for a fresh `start`.

## Timing
- Reset values: `a` = `b` = `c` = 0, `busy` = 0, `done` = 0, `bit_idx` = WIDTH-1.
- Latency: the first bit appears on the same edge that samples `start`, so it is visible in the following cycle.
- Bit k (counting from 0 at MSB) is driven during cycles k·DIV … (k+1)·DIV−1 after the start edge.
- `busy` stays high for exactly WIDTH·DIV cycles per single pass.
- `done` is high in cycle WIDTH·DIV, concurrent with `busy` = 0 when `loop` = 0. If `loop` = 1, cycle WIDTH·DIV shows the first bit of the next pass.
- DIV = 1: a new bit every cycle and the divider is constant 0. The divider width is max(1, $clog2(DIV)).
- `a`, `b` and `c` change on the same edge: no skew between channels at the `nor_gate` inputs.

## Structure
- Shared package `pattern_gen_pkg`:
  - FSM state enum (IDLE, SHIFT).
  - default constants `PG_WIDTH` = 19 and `PG_DIV` = 4.
- One natural sub-module, `tick_divider`: a modulo-DIV counter with a synchronous clear. Its `tick` output is high on count DIV-1.
- Top level holds the FSM, three shadow shift registers (or one 3×WIDTH array) and `bit_idx`.

## Test plan
- WIDTH = 19, DIV = 1:
  - `pat_a` = 0111111000011110000, `pat_b` = 0000111100001111000, `pat_c` = 0010010001000100010, one `start` pulse.
  - Required: `a`/`b`/`c` reproduce each pattern MSB-first over 19 cycles.
  - Required: a `nor_gate` output of 1 occurs only at steps where all three bits are 0 (e.g. step 0 and step 18).
  - Required: `done` is high in cycle 19.
- DIV = 4, `pat_a` = 1010…: each bit is held exactly 4 cycles, `busy` is high for 76 cycles, and `done` is a single pulse.
- `loop` = 1 for two passes, then 0:
  - Required: no idle cycle between passes and a `done` pulse at cycles 19 and 38 (DIV = 1).
  - Required: IDLE after the third pass.
- `start` re-pulsed at cycle 5 and `pat_a` changed at cycle 7: output sequence unchanged, and no restart occurs.
- `reset` low at cycle 10 of a run:
  - Required: outputs are 0 and `busy` = 0 asynchronously, before the next edge, and `bit_idx` = 18.
  - Required: after release, nothing happens until `start`.
- Edge patterns with DIV = 2: all-ones and all-zeros patterns. Required: correct levels for 38 cycles, then a return to 0.
